// File: rtl/gem_ext_fifo_pkg.sv
// gem_ext_fifo_pkg: shared write-FSM encoding and storage word layout for the GEM RX frame buffer
package gem_ext_fifo_pkg;
  typedef enum logic [1:0] {IDLE, RECV, DISCARD} wr_state_e;
  // Marker bit positions above the data field in each stored word
  localparam int SOP_BIT = 0;
  localparam int EOP_BIT = 1;
endpackage

// File: rtl/gem_ext_fifo_rx_buf_if.sv
// gem_ext_fifo_rx_buf_if: GEM ext-FIFO RX write side plus the drained byte stream
interface gem_ext_fifo_rx_buf_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] i_data;
  logic              i_wr;
  logic              i_sop;
  logic              i_eop;
  logic              i_err;
  logic              i_flush;
  logic [44:0]       i_status;
  logic [DATA_W-1:0] o_data;
  logic              o_data_start;
  logic              o_data_end;
  logic              o_valid;
  logic              i_ready;
  modport master (
    output i_data, i_wr, i_sop, i_eop, i_err, i_flush, i_status, i_ready,
    input  o_data, o_data_start, o_data_end, o_valid
  );
  modport slave (
    input  i_data, i_wr, i_sop, i_eop, i_err, i_flush, i_status, i_ready,
    output o_data, o_data_start, o_data_end, o_valid
  );
endinterface

// File: rtl/gem_ext_fifo_ram.sv
// gem_ext_fifo_ram: simple dual-port RAM, one write port, registered read port that holds when not enabled
module gem_ext_fifo_ram #(
  parameter int W     = 10,
  parameter int DEPTH = 2048
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q, rdata_d;
  always_comb rdata_d = re ? mem[raddr] : rdata_q;
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (!resetn) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/gem_ext_fifo_rx_buf.sv
// gem_ext_fifo_rx_buf: buffers GEM RX frames, commits only on clean EOP, drains committed frames as a byte stream
module gem_ext_fifo_rx_buf
  import gem_ext_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2048,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  gem_ext_fifo_rx_buf_if.slave   bus,
  output logic                   o_overflow,
  output logic [CNT_W-1:0]       o_frame_cnt,
  output logic [CNT_W-1:0]       o_drop_cnt,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int WW = DATA_W + 2;
  localparam logic [PW-1:0] FULL_LVL = {1'b1, {AW{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  wr_state_e        state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, cm_ptr_q, cm_ptr_d, rd_ptr_q, rd_ptr_d, base;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;
  logic             ovf_q, ovf_d, valid_q, valid_d;
  logic             we, re, commit, drop, full;
  logic [WW-1:0]    wdata, rdata;
  logic             unused_status;

  assign unused_status = ^bus.i_status;

  // A SOP seen mid-frame restarts at the committed pointer, so space is judged from there
  always_comb begin
    base     = bus.i_sop ? cm_ptr_q : wr_ptr_q;
    full     = (base - rd_ptr_q) == FULL_LVL;
    wr_ptr_d = wr_ptr_q;
    cm_ptr_d = cm_ptr_q;
    state_d  = state_q;
    ovf_d    = 1'b0;
    we       = 1'b0;
    commit   = 1'b0;
    drop     = 1'b0;
    wdata    = {2'b00, bus.i_data};
    wdata[DATA_W+EOP_BIT] = bus.i_eop;
    wdata[DATA_W+SOP_BIT] = bus.i_sop;
    if (bus.i_flush) begin
      wr_ptr_d = cm_ptr_q;
      state_d  = IDLE;
      drop     = state_q == RECV;
    end else if (bus.i_wr) begin
      if (state_q == DISCARD) begin
        state_d = bus.i_eop ? IDLE : DISCARD;
      end else if (state_q == RECV || bus.i_sop) begin
        drop = state_q == RECV && bus.i_sop;
        if (bus.i_err || full) begin
          wr_ptr_d = cm_ptr_q;
          drop     = 1'b1;
          ovf_d    = !bus.i_err;
          state_d  = bus.i_eop ? IDLE : DISCARD;
        end else begin
          we       = 1'b1;
          commit   = bus.i_eop;
          wr_ptr_d = base + PW'(1);
          cm_ptr_d = bus.i_eop ? base + PW'(1) : cm_ptr_q;
          state_d  = bus.i_eop ? IDLE : RECV;
        end
      end
    end
  end

  // The RAM read register is the output stage: fetch whenever it is empty or being consumed
  always_comb begin
    re          = (rd_ptr_q != cm_ptr_q) && (!valid_q || bus.i_ready);
    rd_ptr_d    = re ? rd_ptr_q + PW'(1) : rd_ptr_q;
    valid_d     = re || (valid_q && !bus.i_ready);
    frame_cnt_d = (commit && frame_cnt_q != CNT_MAX) ? frame_cnt_q + CNT_W'(1) : frame_cnt_q;
    drop_cnt_d  = (drop && drop_cnt_q != CNT_MAX) ? drop_cnt_q + CNT_W'(1) : drop_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      cm_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      cm_ptr_q    <= cm_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      ovf_q       <= ovf_d;
      valid_q     <= valid_d;
    end
  end

  gem_ext_fifo_ram #(.W(WW), .DEPTH(DEPTH)) u_ram (
    .clk    (clk),
    .resetn (resetn),
    .we     (we),
    .waddr  (base[AW-1:0]),
    .wdata  (wdata),
    .re     (re),
    .raddr  (rd_ptr_q[AW-1:0]),
    .rdata  (rdata)
  );

  assign bus.o_valid      = valid_q;
  assign bus.o_data       = rdata[DATA_W-1:0];
  assign bus.o_data_start = rdata[DATA_W+SOP_BIT];
  assign bus.o_data_end   = rdata[DATA_W+EOP_BIT];
  assign o_overflow       = ovf_q;
  assign o_frame_cnt      = frame_cnt_q;
  assign o_drop_cnt       = drop_cnt_q;
  assign o_level          = cm_ptr_q - rd_ptr_q;
endmodule

// File: doc/gem_ext_fifo_rx_buf.md
Name: gem_ext_fifo_rx_buf

Overview:
Parametrised packet buffer on the Zynq GEM external-FIFO RX interface, the successor to the simple pass-through RX adapter. Buffers whole frames in a circular store and commits a frame only on a clean EOP. Errored, flushed, truncated or overflowing frames are dropped. Committed frames drain through a valid/ready byte stream with start/end markers, plus frame and drop counters.

Parameters:
DATA_W, 8, data beat width (GEM ext FIFO is 8)
DEPTH, 2048, buffer entries; power of two, >= 16
CNT_W, 16, width of frame/drop counters

Ports:
clk  in  1  system clock
resetn  in  1  synchronous reset, active-low
i_data  in  DATA_W  GEM RX data
i_wr  in  1  GEM write strobe, one beat per cycle
i_sop  in  1  start of frame, qualified by i_wr
i_eop  in  1  end of frame, qualified by i_wr
i_err  in  1  frame error, qualified by i_wr
i_flush  in  1  GEM flush; discards uncommitted data
i_status  in  45  GEM RX status, ignored by this block
o_data  out  DATA_W  output byte
o_data_start  out  1  first byte of frame
o_data_end  out  1  last byte of frame
o_valid  out  1  output beat valid
i_ready  in  1  consumer accepts beat when o_valid&i_ready
o_overflow  out  1  one-cycle pulse: frame dropped because buffer full
o_frame_cnt  out  CNT_W  committed frames, saturating
o_drop_cnt  out  CNT_W  dropped frames (any cause), saturating
o_level  out  log2(DEPTH)+1  committed entries not yet read

Behaviour:
- Reset (resetn=0 at posedge): all pointers 0, write FSM IDLE, o_valid/o_data/o_data_start/o_data_end/o_overflow=0, counters 0, o_level=0. Reset mid-frame discards the partial frame. Reset mid-drain discards the output beat.
- Storage word = {eop, sop, data}. Pointers are log2(DEPTH)+1 bits: wr_ptr (speculative), cm_ptr (committed), rd_ptr.
- Full: wr_ptr-rd_ptr==DEPTH. Empty (read side): rd_ptr==cm_ptr. Uncommitted data is never visible to the reader.
- Write FSM, evaluated on i_wr beats; i_flush has highest priority in every state (wr_ptr<=cm_ptr, ->IDLE, drop counted if a frame was open):
  - IDLE: i_wr&i_sop writes beat, ->RECV. i_wr without i_sop is ignored and not counted. sop&eop in the same beat is a one-byte frame: write and commit.
  - RECV: i_wr writes. i_wr&i_eop&!i_err: write, cm_ptr<=wr_ptr+1, frame_cnt++, ->IDLE. i_wr&i_err: wr_ptr<=cm_ptr, drop++, ->IDLE if i_eop else DISCARD. i_wr&i_sop (missing EOP): rewind, drop++, new frame starts with this beat, stay RECV.
  - Write attempted while full: rewind, drop++, o_overflow=1 for one cycle, ->IDLE if i_eop else DISCARD.
  - DISCARD: ignore beats until i_wr&i_eop, then ->IDLE. i_wr&i_sop&i_eop also ->IDLE.
- Read side: FWFT with registered output. Memory read latency 1 cycle. After an EOP commit at cycle E with the buffer empty and the output idle, o_valid=1 at cycle E+2 with o_data_start=1. Full throughput of 1 beat/cycle while i_ready=1. o_data/o_data_start/o_data_end stay stable while o_valid&!i_ready. No bubble between back-to-back committed frames.
- Simultaneous write and read at the full boundary: a read in the same cycle does not free space for that cycle's write; full is evaluated on the registered pointers.
- o_level = cm_ptr-rd_ptr, where rd_ptr counts entries fetched into the output register.
- Counters saturate at 2^CNT_W-1 and do not wrap.

Decomposition:
- Package gem_ext_fifo_pkg: write FSM state encoding (IDLE, RECV, DISCARD) and word-field bit positions (EOP_BIT, SOP_BIT).
- Sub-module gem_ext_fifo_ram: simple dual-port RAM, DEPTH x (DATA_W+2), one write port, registered read port. Pointer, commit and FSM logic stay in the top.

Test Plan:
- Clean 64-byte frame 0x00..0x3F, i_ready=1 -> 64 beats out in order, start on 0x00, end on 0x3F, first o_valid at E+2, o_frame_cnt=1, o_drop_cnt=0.
- Frame with i_err on byte 10, then a clean 4-byte frame -> only the 4-byte frame appears, o_drop_cnt=1, o_level never counts the errored bytes.
- DEPTH=16, i_ready=0, 20-byte frame -> o_overflow pulses once on byte 17, frame dropped, o_level=0. Next 8-byte frame commits, and after i_ready=1 is read out intact.
- i_flush mid-frame after 5 bytes, then bytes without SOP, then a clean 3-byte frame -> only the 3-byte frame out, o_drop_cnt=1.
- Two back-to-back 1-byte frames (sop&eop), i_ready toggling 1/0 each cycle -> two beats each with start=end=1, data held stable while stalled, o_frame_cnt=2.
- resetn=0 for one cycle mid-drain -> all outputs 0 next cycle, o_level=0, following frame passes normally.
